// File: rtl/stage_mm.sv
// Memory-access stage: issues one req/ack data-bus transaction per load/store and registers the result toward writeback.
// Non-memory ops pass through in 1 cycle; loads/stores hold out_stall high from capture until the result is written.
module stage_mm #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  reg_wr,
    input  logic [REG_ADDR_W-1:0] reg_addr_rd,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  out_stall,
    output logic                  out_reg_wr,
    output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
    output logic [DATA_W-1:0]     out_reg_data,
    output logic                  out_flush,
    output logic                  out_err,
    output logic [1:0]            out_err_code
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                  state, state_nxt;
    logic [7:0]              cnt;
    logic                    go;
    logic                    is_mem;
    logic                    misal;
    logic                    do_cap, do_misal, do_conf, do_fin, do_buf, do_tmo;
    logic [DATA_W-1:0]       fin_data;
    logic                    pend_wr;
    logic                    pend_load;
    logic [REG_ADDR_W-1:0]   pend_rd_addr;
    logic [DATA_W-1:0]       rbuf;

    assign go        = en && !stall;
    assign is_mem    = mem_rd || mem_wr;
    assign misal     = (alu_res[1:0] != 2'b00);
    assign out_stall = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_cap    = 1'b0;
        do_misal  = 1'b0;
        do_conf   = 1'b0;
        do_fin    = 1'b0;
        do_buf    = 1'b0;
        do_tmo    = 1'b0;
        fin_data  = bus_addr;
        case (state)
            IDLE: begin
                if (go && !flush && is_mem) begin
                    if (misal) begin
                        do_misal = 1'b1;
                    end else begin
                        do_cap    = 1'b1;
                        do_conf   = mem_rd && mem_wr;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (pend_load) fin_data = bus_rdata;
                // A same-cycle ack always beats the timeout.
                if (bus_ack) begin
                    if (go) begin
                        do_fin    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        do_buf    = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (cnt == TMO_LAST) begin
                    do_tmo    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (pend_load) fin_data = rbuf;
                if (go) begin
                    do_fin    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
            pend_wr         <= 1'b0;
            pend_load       <= 1'b0;
            pend_rd_addr    <= '0;
            rbuf            <= '0;
            out_reg_wr      <= 1'b0;
            out_reg_addr_rd <= '0;
            out_reg_data    <= '0;
            out_flush       <= 1'b1;
            out_err         <= 1'b0;
            out_err_code    <= 2'b00;
        end else begin
            if (state == IDLE && go) begin
                if (flush || is_mem) begin
                    out_flush  <= 1'b1;
                    out_reg_wr <= 1'b0;
                end else begin
                    out_flush       <= 1'b0;
                    out_reg_wr      <= reg_wr;
                    out_reg_addr_rd <= reg_addr_rd;
                    out_reg_data    <= alu_res;
                end
            end
            if (do_cap) begin
                cnt          <= '0;
                bus_req      <= 1'b1;
                bus_we       <= mem_wr;
                bus_addr     <= alu_res;
                bus_wdata    <= mem_wdata;
                pend_wr      <= reg_wr && !mem_wr;
                pend_load    <= mem_rd && !mem_wr;
                pend_rd_addr <= reg_addr_rd;
            end else if (state == REQ && !bus_ack) begin
                cnt <= cnt + 8'd1;
            end
            if (do_fin || do_buf || do_tmo) bus_req <= 1'b0;
            if (do_buf) rbuf <= bus_rdata;
            if (do_fin) begin
                out_flush       <= 1'b0;
                out_reg_wr      <= pend_wr;
                out_reg_addr_rd <= pend_rd_addr;
                out_reg_data    <= fin_data;
            end
            if (do_misal) begin
                out_err      <= 1'b1;
                out_err_code <= 2'b01;
            end
            if (do_conf) begin
                out_err      <= 1'b1;
                out_err_code <= 2'b10;
            end
            if (do_tmo) begin
                out_err      <= 1'b1;
                out_err_code <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_stage_mm.sv
// Bench for stage_mm: scripted instructions, a bus responder with programmable ack delay, and a writeback scoreboard.
module tb_stage_mm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b1;
    logic        reg_wr = 1'b0;
    logic [4:0]  reg_addr_rd = '0;
    logic [31:0] alu_res = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        out_stall, out_reg_wr, out_flush, out_err;
    logic [4:0]  out_reg_addr_rd;
    logic [31:0] out_reg_data;
    logic [1:0]  out_err_code;

    stage_mm #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
        .reg_wr(reg_wr), .reg_addr_rd(reg_addr_rd), .alu_res(alu_res),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .out_stall(out_stall), .out_reg_wr(out_reg_wr),
        .out_reg_addr_rd(out_reg_addr_rd), .out_reg_data(out_reg_data),
        .out_flush(out_flush), .out_err(out_err), .out_err_code(out_err_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard entries are {reg_wr, rd, data}.
    logic [37:0] sb[$];

    // Bus responder: ack on the ack_delay-th REQ cycle (counting from 0); -1 never acks.
    int          ack_delay  = -1;
    logic [31:0] ack_data   = '0;
    logic        manual_ack = 1'b0;
    logic [31:0] exp_addr   = '0;
    logic        exp_we     = 1'b0;
    logic [31:0] exp_wdata  = '0;
    int          req_cyc    = 0;

    always @(negedge clk) begin
        bus_ack = manual_ack;
        if (bus_req && rst_n) begin
            check("bus_addr_stable", 64'(bus_addr), 64'(exp_addr));
            check("bus_we_stable", 64'(bus_we), 64'(exp_we));
            if (exp_we) check("bus_wdata_stable", 64'(bus_wdata), 64'(exp_wdata));
            if (req_cyc == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = ack_data;
            end
            req_cyc++;
        end else begin
            req_cyc = 0;
        end
    end

    // Writeback monitor: every new non-bubble output slot pops one expectation.
    logic [37:0] last_out = '0;
    logic        last_fl  = 1'b1;
    always @(negedge clk) begin
        logic [37:0] cur;
        logic [37:0] e;
        cur = {out_reg_wr, out_reg_addr_rd, out_reg_data};
        if (rst_n && !out_flush && (last_fl || cur != last_out)) begin
            check("sb_avail", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wb_result", 64'(cur), 64'(e));
            end
        end
        last_out = cur;
        last_fl  = out_flush;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic mr, input logic mw, input logic [31:0] wd);
        flush = f; reg_wr = rw; reg_addr_rd = rd; alu_res = alu;
        mem_rd = mr; mem_wr = mw; mem_wdata = wd;
    endtask

    task automatic bubble();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (out_stall && n < 200) begin
            n++;
            cyc();
        end
        if (out_stall) check("wait_idle_bound", 64'(out_stall), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_flush", 64'(out_flush), 64'(1));
        check("rst_out_reg_wr", 64'(out_reg_wr), 64'(0));
        check("rst_out_reg_data", 64'(out_reg_data), 64'(0));
        check("rst_bus_req", 64'(bus_req), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_out_stall", 64'(out_stall), 64'(0));
        rst_n = 1'b1;

        // Pass-through
        drive(1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
        sb.push_back({1'b1, 5'd7, 32'h0000_1234});
        cyc();
        check("pt_stall", 64'(out_stall), 64'(0));
        check("pt_flush", 64'(out_flush), 64'(0));

        // Load acked on the third REQ cycle, pass-through held behind it
        drive(1'b0, 1'b1, 5'd3, 32'h0000_0100, 1'b1, 1'b0, 32'h0);
        ack_delay = 2; ack_data = 32'hDEAD_BEEF;
        exp_addr = 32'h100; exp_we = 1'b0; exp_wdata = 32'h0;
        sb.push_back({1'b1, 5'd3, 32'hDEAD_BEEF});
        cyc();
        check("ld_bus_req", 64'(bus_req), 64'(1));
        check("ld_bus_we", 64'(bus_we), 64'(0));
        check("ld_bus_addr", 64'(bus_addr), 64'(32'h100));
        check("ld_slot_bubble", 64'(out_flush), 64'(1));
        drive(1'b0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 1'b0, 32'h0);
        sb.push_back({1'b1, 5'd9, 32'h0000_0055});
        wait_idle(n);
        check("ld_stall_cycles", 64'(n), 64'(3));
        check("ld_rd", 64'(out_reg_addr_rd), 64'(3));
        cyc();
        check("held_pt_rd", 64'(out_reg_addr_rd), 64'(9));

        // Store
        drive(1'b0, 1'b1, 5'd4, 32'h0000_0204, 1'b0, 1'b1, 32'hA5A5_A5A5);
        ack_delay = 1;
        exp_addr = 32'h204; exp_we = 1'b1; exp_wdata = 32'hA5A5_A5A5;
        sb.push_back({1'b0, 5'd4, 32'h0000_0204});
        cyc();
        check("st_bus_we", 64'(bus_we), 64'(1));
        check("st_bus_wdata", 64'(bus_wdata), 64'(32'hA5A5_A5A5));
        bubble();
        wait_idle(n);
        check("st_stall_cycles", 64'(n), 64'(2));
        check("st_out_reg_wr", 64'(out_reg_wr), 64'(0));
        check("st_out_flush", 64'(out_flush), 64'(0));
        cyc();

        // Stall on the ack cycle
        drive(1'b0, 1'b1, 5'd5, 32'h0000_0300, 1'b1, 1'b0, 32'h0);
        ack_delay = 0; ack_data = 32'h0BAD_F00D;
        exp_addr = 32'h300; exp_we = 1'b0;
        sb.push_back({1'b1, 5'd5, 32'h0BAD_F00D});
        cyc();
        stall = 1'b1;
        cyc();
        check("sa_bus_req", 64'(bus_req), 64'(0));
        check("sa_stall_out", 64'(out_stall), 64'(1));
        check("sa_out_flush", 64'(out_flush), 64'(1));
        check("sa_out_data_held", 64'(out_reg_data), 64'(32'h204));
        cyc();
        check("sa_still_stalled", 64'(out_stall), 64'(1));
        bubble();
        stall = 1'b0;
        cyc();
        check("sa_release_stall", 64'(out_stall), 64'(0));
        check("sa_out_data", 64'(out_reg_data), 64'(32'h0BAD_F00D));

        // Misaligned load
        drive(1'b0, 1'b1, 5'd6, 32'h0000_0102, 1'b1, 1'b0, 32'h0);
        cyc();
        check("mis_bus_req", 64'(bus_req), 64'(0));
        check("mis_err", 64'(out_err), 64'(1));
        check("mis_code", 64'(out_err_code), 64'(1));
        check("mis_stall", 64'(out_stall), 64'(0));
        check("mis_flush", 64'(out_flush), 64'(1));

        // Read+write conflict behaves as a store
        drive(1'b0, 1'b1, 5'd8, 32'h0000_0400, 1'b1, 1'b1, 32'h1111_2222);
        ack_delay = 0;
        exp_addr = 32'h400; exp_we = 1'b1; exp_wdata = 32'h1111_2222;
        sb.push_back({1'b0, 5'd8, 32'h0000_0400});
        cyc();
        check("cf_bus_we", 64'(bus_we), 64'(1));
        check("cf_code", 64'(out_err_code), 64'(2));
        bubble();
        wait_idle(n);
        check("cf_stall_cycles", 64'(n), 64'(1));
        cyc();

        // Timeout
        drive(1'b0, 1'b1, 5'd10, 32'h0000_0500, 1'b1, 1'b0, 32'h0);
        ack_delay = -1;
        exp_addr = 32'h500; exp_we = 1'b0;
        cyc();
        bubble();
        wait_idle(n);
        check("to_stall_cycles", 64'(n), 64'(16));
        check("to_bus_req", 64'(bus_req), 64'(0));
        check("to_code", 64'(out_err_code), 64'(3));
        check("to_err", 64'(out_err), 64'(1));
        check("to_flush", 64'(out_flush), 64'(1));

        // Flush with a load pending at the inputs
        drive(1'b1, 1'b1, 5'd12, 32'h0000_0600, 1'b1, 1'b0, 32'h0);
        cyc();
        check("fl_bus_req", 64'(bus_req), 64'(0));
        check("fl_flush", 64'(out_flush), 64'(1));
        check("fl_stall", 64'(out_stall), 64'(0));

        // Reset in the middle of a transaction
        drive(1'b0, 1'b1, 5'd11, 32'h0000_0700, 1'b1, 1'b0, 32'h0);
        ack_delay = 3;
        exp_addr = 32'h700; exp_we = 1'b0;
        cyc();
        check("mr_bus_req", 64'(bus_req), 64'(1));
        bubble();
        #2 rst_n = 1'b0;
        #1;
        check("mr_bus_req_drop", 64'(bus_req), 64'(0));
        check("mr_flush", 64'(out_flush), 64'(1));
        check("mr_err_clear", 64'(out_err), 64'(0));
        check("mr_code_clear", 64'(out_err_code), 64'(0));
        check("mr_stall", 64'(out_stall), 64'(0));
        cyc();
        rst_n = 1'b1;
        manual_ack = 1'b1;
        repeat (3) cyc();
        manual_ack = 1'b0;
        check("late_ack_bus_req", 64'(bus_req), 64'(0));
        check("late_ack_stall", 64'(out_stall), 64'(0));
        check("late_ack_flush", 64'(out_flush), 64'(1));
        cyc();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
